// File: rtl/m8x8_seq_pkg.sv
// m8x8_seq_pkg: shared constants and types for the 8x8 systolic array sequencer.
//   DW        word width of every array lane
//   N         array dimension (rows = columns)
//   FLUSH_LEN cycles of zero injection after the last slice
//   DRAIN_LEN result columns drained per tile
//   CONF_*    bit positions inside the 4-bit array config word
package m8x8_seq_pkg;
   localparam int DW        = 32;
   localparam int N         = 8;
   localparam int FLUSH_LEN = 15;
   localparam int DRAIN_LEN = 8;
   localparam int CONF_TR   = 0;
   localparam int CONF_RELU = 1;

   typedef enum logic [2:0] {S_IDLE, S_FEED, S_FLUSH, S_SHIFT, S_DRAIN} state_t;

   typedef logic [N-1:0][DW-1:0] vec_t;

   // One slice as it enters the skew network: W row, X column, clear marker.
   typedef struct packed {
      vec_t w;
      vec_t x;
      logic clr;
   } slice_t;
endpackage

// File: rtl/m8x8_seq_skew_line.sv
// m8x8_seq_skew_line: enable-gated delay line used to skew one row or column.
//   clk, reset  clock, asynchronous active-high reset (clears every stage)
//   en          advance the line by one stage
//   d / q       data in / data out, DEPTH enabled cycles later
// DEPTH must be >= 1; the undelayed lane is a plain wire in the top.
module m8x8_seq_skew_line
   import m8x8_seq_pkg::*;
#(
   parameter int DEPTH = 1,
   parameter int WIDTH = DW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [DEPTH-1:0][WIDTH-1:0] sr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr <= '0;
      end else if (en) begin
         sr[0] <= d;
         for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
      end
   end

   assign q = sr[DEPTH-1];
endmodule

// File: rtl/m8x8_seq.sv
// m8x8_seq: sequencer and result collector for the 8x8 systolic MAC array.
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     K-slice handshake; in_w/in_x slice data, in_last ends tile
//   conf_in               array config, captured with the first slice of a tile
//   out_valid/out_ready   result handshake; out_z/out_b one column, out_col, out_last
//   arr_w/arr_x/arr_y     skewed array inputs (arr_y is always zero)
//   arr_clear/arr_shift   per-row controls; arr_enable global stall, arr_reset sync reset
//   arr_conf              config held for the tile; arr_z/arr_b array result taps
//   busy                  sequencer not idle
// Optional macro M8X8_SEQ_PERF_EN adds saturating counters perf_busy / perf_stall.
module m8x8_seq
   import m8x8_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0][DW-1:0] in_w,
   input  logic [N-1:0][DW-1:0] in_x,
   input  logic                 in_last,
   input  logic [3:0]           conf_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N-1:0][DW-1:0] out_z,
   output logic [N-1:0]         out_b,
   output logic [2:0]           out_col,
   output logic                 out_last,
   output logic [N-1:0][DW-1:0] arr_w,
   output logic [N-1:0][DW-1:0] arr_x,
   output logic [N-1:0][DW-1:0] arr_y,
   output logic [N-1:0]         arr_clear,
   output logic [N-1:0]         arr_shift,
   output logic                 arr_enable,
   output logic                 arr_reset,
   output logic [3:0]           arr_conf,
   input  logic [N-1:0][DW-1:0] arr_z,
   input  logic [N-1:0]         arr_b,
   output logic                 busy
`ifdef M8X8_SEQ_PERF_EN
  ,output logic [31:0]          perf_busy,
   output logic [31:0]          perf_stall
`endif
);
   state_t     state;
   logic [3:0] fcnt;
   logic       accept;
   slice_t     inj;

   // Holding ready low while arr_reset is still up keeps a slice from
   // landing in the same cycle the array is being reset.
   assign in_ready = (state == S_IDLE || state == S_FEED) && !arr_reset;
   assign accept   = in_valid && in_ready;
   assign busy     = (state != S_IDLE);
   assign arr_y    = '0;
   assign arr_shift = {N{state == S_SHIFT}};

   // Outputs are only meaningful while draining; zero otherwise.
   assign out_z = out_valid ? arr_z : '0;
   assign out_b = out_valid ? arr_b : '0;

   // Injected slice and global enable. Every non-accepting cycle injects
   // zeros, so gaps and flush add nothing to the accumulators.
   always_comb begin
      inj        = '0;
      arr_enable = 1'b0;
      case (state)
         S_IDLE, S_FEED: begin
            arr_enable = accept;
            if (accept) begin
               inj.w   = in_w;
               inj.x   = in_x;
               inj.clr = (state == S_IDLE);
            end
         end
         S_FLUSH: begin
            arr_enable = 1'b1;
            inj.clr    = (fcnt == 4'd0);   // closing clear finishes the tile
         end
         S_SHIFT: arr_enable = 1'b1;
         S_DRAIN: arr_enable = out_ready;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         fcnt      <= '0;
         arr_conf  <= '0;
         out_valid <= 1'b0;
         out_col   <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               arr_conf <= conf_in;
               state    <= in_last ? S_FLUSH : S_FEED;
               fcnt     <= '0;
            end
            S_FEED: if (accept && in_last) begin
               state <= S_FLUSH;
               fcnt  <= '0;
            end
            S_FLUSH: begin
               if (fcnt == 4'(FLUSH_LEN - 1)) begin
                  state <= S_SHIFT;
                  fcnt  <= '0;
               end else begin
                  fcnt <= fcnt + 4'd1;
               end
            end
            S_SHIFT: begin
               state     <= S_DRAIN;
               out_valid <= 1'b1;
               out_col   <= '0;
               out_last  <= 1'b0;
            end
            S_DRAIN: if (out_ready) begin
               if (out_col == 3'(DRAIN_LEN - 1)) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  out_col   <= '0;
                  out_last  <= 1'b0;
               end else begin
                  out_col  <= out_col + 3'd1;
                  out_last <= (out_col == 3'(DRAIN_LEN - 2));
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Set asynchronously, dropped on the first edge after release so the
   // array always sees at least one clock with its sync reset high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) arr_reset <= 1'b1;
      else       arr_reset <= 1'b0;
   end

   // Rows carry X plus the clear marker, columns carry W; lane 0 is undelayed.
   for (genvar i = 0; i < N; i++) begin : g_row
      if (i == 0) begin : g_comb
         assign arr_x[0]     = inj.x[0];
         assign arr_clear[0] = inj.clr;
      end else begin : g_dly
         logic [DW:0] q;
         m8x8_seq_skew_line #(.DEPTH(i), .WIDTH(DW + 1)) u_line (
            .clk   (clk),
            .reset (reset),
            .en    (arr_enable),
            .d     ({inj.clr, inj.x[i]}),
            .q     (q)
         );
         assign arr_x[i]     = q[DW-1:0];
         assign arr_clear[i] = q[DW];
      end
   end

   for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_comb
         assign arr_w[0] = inj.w[0];
      end else begin : g_dly
         m8x8_seq_skew_line #(.DEPTH(j), .WIDTH(DW)) u_line (
            .clk   (clk),
            .reset (reset),
            .en    (arr_enable),
            .d     (inj.w[j]),
            .q     (arr_w[j])
         );
      end
   end

`ifdef M8X8_SEQ_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_busy  <= '0;
         perf_stall <= '0;
      end else begin
         if (busy && ~&perf_busy) perf_busy <= perf_busy + 32'd1;
         if (busy && !arr_enable && ~&perf_stall) perf_stall <= perf_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_m8x8_seq.sv
module tb_m8x8_seq;
   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid, in_ready, in_last;
   logic [7:0][31:0]  in_w, in_x;
   logic [3:0]        conf_in;
   logic              out_valid, out_ready, out_last;
   logic [7:0][31:0]  out_z;
   logic [7:0]        out_b;
   logic [2:0]        out_col;
   logic [7:0][31:0]  arr_w, arr_x, arr_y, arr_z;
   logic [7:0]        arr_clear, arr_shift, arr_b;
   logic              arr_enable, arr_reset, busy;
   logic [3:0]        arr_conf;
`ifdef M8X8_SEQ_PERF_EN
   logic [31:0]       perf_busy, perf_stall;
`endif

   always #5 clk = ~clk;

   m8x8_seq dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_w(in_w), .in_x(in_x),
      .in_last(in_last), .conf_in(conf_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .out_b(out_b),
      .out_col(out_col), .out_last(out_last),
      .arr_w(arr_w), .arr_x(arr_x), .arr_y(arr_y),
      .arr_clear(arr_clear), .arr_shift(arr_shift),
      .arr_enable(arr_enable), .arr_reset(arr_reset), .arr_conf(arr_conf),
      .arr_z(arr_z), .arr_b(arr_b), .busy(busy)
`ifdef M8X8_SEQ_PERF_EN
     ,.perf_busy(perf_busy), .perf_stall(perf_stall)
`endif
   );

   // ---------------- output-stationary 8x8 array model ----------------
   // x flows right along rows with its clear bit, w flows down columns.
   // A clear retires the accumulator into res; shift loads res into the
   // output buffer, which then drains one column to the left per enable.
   logic [31:0] xr [8][8], wr [8][8], acc [8][8], res [8][8], ob [8][8];
   logic        cr [8][8];
   logic [31:0] xin [8][8], win [8][8];
   logic        cin [8][8];

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         xin[i][0] = arr_x[i];
         cin[i][0] = arr_clear[i];
         for (int j = 1; j < 8; j++) begin
            xin[i][j] = xr[i][j-1];
            cin[i][j] = cr[i][j-1];
         end
      end
      for (int j = 0; j < 8; j++) begin
         win[0][j] = arr_w[j];
         for (int i = 1; i < 8; i++) win[i][j] = wr[i-1][j];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            if (arr_reset) begin
               xr[i][j] <= '0; wr[i][j] <= '0; cr[i][j] <= 1'b0;
               acc[i][j] <= '0; res[i][j] <= '0; ob[i][j] <= '0;
            end else if (arr_enable) begin
               xr[i][j] <= xin[i][j];
               wr[i][j] <= win[i][j];
               cr[i][j] <= cin[i][j];
               if (cin[i][j]) begin
                  res[i][j] <= acc[i][j];
                  acc[i][j] <= xin[i][j] * win[i][j];
               end else begin
                  acc[i][j] <= acc[i][j] + xin[i][j] * win[i][j];
               end
               if (arr_shift[i]) ob[i][j] <= res[i][j];
               else if (j == 7) ob[i][j] <= '0;
               else             ob[i][j] <= ob[i][j+1];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         arr_z[i] = (arr_conf[1] && $signed(ob[i][0]) < 0) ? 32'd0 : ob[i][0];
         arr_b[i] = ($signed(ob[i][0]) > 0);
      end
   end

   // ---------------- bench state ----------------
   int n_cmp = 0, n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int               tw [16][8], tx [16][8];
   int               tk;
   logic [3:0]       tconf;
   logic [7:0][31:0] ezc [8];
   logic [7:0]       eb [8];
   logic [7:0][31:0] cz [8], gz [8];
   logic [7:0]       cb [8];
   logic [2:0]       ccol [8];
   logic             clast [8];
   logic [3:0]       c_conf;
   int               first_valid, last_acc, hold_bad, gap_bad;
   bit               d_to, s_to;
   logic             post_valid, post_busy;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Expected result straight from the matrix definition:
   // z[i][j] = sum_k X(k,i) * W(k,j), relu clamps negatives, b = z > 0.
   task automatic ref_tile();
      int s;
      for (int j = 0; j < 8; j++) begin
         for (int i = 0; i < 8; i++) begin
            s = 0;
            for (int k = 0; k < tk; k++) s += tx[k][i] * tw[k][j];
            if (tconf[1] && s < 0) s = 0;
            ezc[j][i] = s;
            eb[j][i]  = (s > 0);
         end
      end
   endtask

   task automatic send_tile(input int gap_after, input int gap_len);
      int t;
      s_to = 0; gap_bad = 0;
      for (int k = 0; k < tk; k++) begin
         if (gap_after >= 0 && k == gap_after + 1) begin
            in_valid = 1'b0;
            for (int g = 0; g < gap_len; g++) begin
               #1;
               if (arr_enable !== 1'b0) gap_bad++;
               tick();
            end
         end
         in_valid = 1'b1; in_last = (k == tk - 1); conf_in = tconf;
         for (int j = 0; j < 8; j++) begin
            in_w[j] = tw[k][j];
            in_x[j] = tx[k][j];
         end
         t = 0;
         while (!in_ready && t < 100) begin tick(); t++; end
         if (!in_ready) s_to = 1;
         if (k == tk - 1) last_acc = cyc;
         tick();
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain(input int stall_col, input int stall_len);
      int t;
      d_to = 0; hold_bad = 0; out_ready = 1'b1; t = 0;
      while (!out_valid && t < 200) begin tick(); t++; end
      first_valid = cyc;
      c_conf = arr_conf;
      for (int c = 0; c < 8; c++) begin
         if (!out_valid) begin d_to = 1; break; end
         cz[c] = out_z; cb[c] = out_b; ccol[c] = out_col; clast[c] = out_last;
         if (c == stall_col) begin
            out_ready = 1'b0;
            for (int s = 0; s < stall_len; s++) begin
               #1;
               if (arr_enable !== 1'b0 || out_z !== cz[c] || out_col !== ccol[c] ||
                   out_valid !== 1'b1) hold_bad++;
               tick();
            end
            if (out_z !== cz[c] || out_b !== cb[c]) hold_bad++;
            out_ready = 1'b1;
         end
         tick();
      end
      post_valid = out_valid; post_busy = busy;
   endtask

   task automatic fill(input int k, input int wv, input int xv);
      tk = k;
      for (int a = 0; a < k; a++)
         for (int b = 0; b < 8; b++) begin tw[a][b] = wv; tx[a][b] = xv; end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; in_valid = 0; in_last = 0; in_w = '0; in_x = '0;
      conf_in = '0; out_ready = 1'b0;
      tick(); tick();
      n_cmp++;
      if ({in_ready, busy, out_valid, out_last, out_col} !== 6'b0) begin
         n_err++; $display("FAIL reset_hs got rdy=%b busy=%b ov=%b ol=%b col=%0d want all 0",
                           in_ready, busy, out_valid, out_last, out_col);
      end
      n_cmp++;
      if ({arr_enable, arr_shift, arr_clear, arr_conf, arr_reset} !== 22'h1) begin
         n_err++; $display("FAIL reset_arr got en=%b sh=%h cl=%h conf=%h ar=%b want 0/0/0/0/1",
                           arr_enable, arr_shift, arr_clear, arr_conf, arr_reset);
      end
      n_cmp++;
      if ({arr_w, arr_x, arr_y, out_z, out_b} !== '0) begin
         n_err++; $display("FAIL reset_data got nonzero array/output data want 0");
      end
      reset = 1'b0;
      tick();
      n_cmp++;
      if (in_ready !== 1'b1 || arr_reset !== 1'b0) begin
         n_err++; $display("FAIL reset_release got rdy=%b ar=%b want 1/0", in_ready, arr_reset);
      end
   endtask

   task automatic test_k1();
      fill(1, 3, 5); tconf = 4'b0000; ref_tile();
      send_tile(-1, 0); drain(-1, 0);
      n_cmp++;
      if (s_to || d_to) begin n_err++; $display("FAIL k1_timeout got s=%b d=%b want 0", s_to, d_to); end
      for (int c = 0; c < 8; c++) begin
         n_cmp++;
         if (cz[c] !== ezc[c] || ezc[c][0] !== 32'd15) begin
            n_err++; $display("FAIL k1_z col%0d got %h want %h", c, cz[c], ezc[c]);
         end
         n_cmp++;
         if (cb[c] !== 8'hFF || ccol[c] !== 3'(c) || clast[c] !== (c == 7)) begin
            n_err++; $display("FAIL k1_meta col%0d got b=%h col=%0d last=%b want FF/%0d/%b",
                              c, cb[c], ccol[c], clast[c], c, c == 7);
         end
      end
      n_cmp++;
      if (first_valid - last_acc !== 17) begin
         n_err++; $display("FAIL k1_latency got %0d want 17", first_valid - last_acc);
      end
      n_cmp++;
      if (post_valid !== 1'b0 || post_busy !== 1'b0) begin
         n_err++; $display("FAIL k1_idle got ov=%b busy=%b want 0/0", post_valid, post_busy);
      end
   endtask

   task automatic ident_tile();
      tk = 8; tconf = 4'b0000;
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 8; j++) begin
            tw[k][j] = j + 1;
            tx[k][j] = (k == j) ? 1 : 0;
         end
      ref_tile();
   endtask

   task automatic test_identity();
      ident_tile();
      send_tile(-1, 0); drain(-1, 0);
      for (int c = 0; c < 8; c++) begin
         gz[c] = cz[c];
         n_cmp++;
         if (d_to || cz[c] !== ezc[c] || cz[c][5] !== 32'(c + 1)) begin
            n_err++; $display("FAIL ident_z col%0d got %h want %h", c, cz[c], ezc[c]);
         end
      end
      n_cmp++;
      if (first_valid - last_acc !== 17) begin
         n_err++; $display("FAIL ident_latency got %0d want 17", first_valid - last_acc);
      end
   endtask

   task automatic test_gap();
      ident_tile();
      send_tile(4, 3); drain(-1, 0);
      n_cmp++;
      if (gap_bad !== 0) begin n_err++; $display("FAIL gap_enable got %0d enabled gap cycles want 0", gap_bad); end
      for (int c = 0; c < 8; c++) begin
         n_cmp++;
         if (d_to || cz[c] !== gz[c] || cz[c] !== ezc[c]) begin
            n_err++; $display("FAIL gap_z col%0d got %h want %h", c, cz[c], gz[c]);
         end
      end
   endtask

   task automatic test_backpressure();
      tk = 4; tconf = 4'b0000;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 8; j++) begin
            tw[k][j] = int'($urandom_range(0, 40)) - 20;
            tx[k][j] = int'($urandom_range(0, 40)) - 20;
         end
      ref_tile();
      send_tile(-1, 0); drain(3, 5);
      n_cmp++;
      if (hold_bad !== 0) begin n_err++; $display("FAIL bp_hold got %0d bad stall cycles want 0", hold_bad); end
      for (int c = 0; c < 8; c++) begin
         n_cmp++;
         if (d_to || cz[c] !== ezc[c] || cb[c] !== eb[c] || ccol[c] !== 3'(c)) begin
            n_err++; $display("FAIL bp_col%0d got z=%h b=%h col=%0d want z=%h b=%h col=%0d",
                              c, cz[c], cb[c], ccol[c], ezc[c], eb[c], c);
         end
      end
   endtask

   task automatic test_relu();
      fill(1, -2, 1); tconf = 4'b0010; ref_tile();
      send_tile(-1, 0); drain(-1, 0);
      n_cmp++;
      if (c_conf !== 4'b0010) begin n_err++; $display("FAIL relu_conf got %b want 0010", c_conf); end
      for (int c = 0; c < 8; c++) begin
         n_cmp++;
         if (d_to || cz[c] !== '0 || cb[c] !== 8'h00 || cz[c] !== ezc[c]) begin
            n_err++; $display("FAIL relu_col%0d got z=%h b=%h want 0/0", c, cz[c], cb[c]);
         end
      end
   endtask

   task automatic test_reset_mid();
      fill(1, 7, 9); tconf = 4'b0110;
      send_tile(-1, 0);
      repeat (7) tick();         // now at FLUSH f=7
      n_cmp++;
      if (busy !== 1'b1 || arr_conf !== 4'b0110) begin
         n_err++; $display("FAIL mid_pre got busy=%b conf=%b want 1/0110", busy, arr_conf);
      end
      reset = 1'b1; #1;
      n_cmp++;
      if ({out_valid, out_last, out_col, out_z, out_b} !== '0 || in_ready !== 1'b0) begin
         n_err++; $display("FAIL mid_out got ov=%b col=%0d z=%h rdy=%b want 0", out_valid, out_col, out_z, in_ready);
      end
      n_cmp++;
      if ({arr_enable, arr_shift, arr_clear, arr_conf} !== '0 || arr_reset !== 1'b1 || busy !== 1'b0) begin
         n_err++; $display("FAIL mid_arr got en=%b cl=%h conf=%b ar=%b busy=%b want 0/0/0/1/0",
                           arr_enable, arr_clear, arr_conf, arr_reset, busy);
      end
      tick(); tick();
      reset = 1'b0;
      tick();
      n_cmp++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++; $display("FAIL mid_release got rdy=%b busy=%b want 1/0", in_ready, busy);
      end
      fill(1, 3, 5); tconf = 4'b0000; ref_tile();
      send_tile(-1, 0); drain(-1, 0);
      for (int c = 0; c < 8; c++) begin
         n_cmp++;
         if (d_to || cz[c] !== ezc[c] || cz[c][7] !== 32'd15) begin
            n_err++; $display("FAIL mid_after col%0d got %h want %h", c, cz[c], ezc[c]);
         end
      end
   endtask

   task automatic test_random();
      int ga;
      for (int n = 0; n < 4; n++) begin
         tk = int'($urandom_range(1, 10));
         tconf = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
         for (int k = 0; k < tk; k++)
            for (int j = 0; j < 8; j++) begin
               tw[k][j] = int'($urandom_range(0, 2000)) - 1000;
               tx[k][j] = int'($urandom_range(0, 2000)) - 1000;
            end
         ref_tile();
         ga = (tk > 1) ? int'($urandom_range(0, tk - 2)) : -1;
         send_tile(ga, int'($urandom_range(0, 4)));
         drain(int'($urandom_range(0, 9)), int'($urandom_range(1, 3)));
         n_cmp++;
         if (s_to || d_to || hold_bad !== 0 || gap_bad !== 0) begin
            n_err++; $display("FAIL rand%0d_flow got s=%b d=%b hold=%0d gap=%0d want 0", n, s_to, d_to, hold_bad, gap_bad);
         end
         for (int c = 0; c < 8; c++) begin
            n_cmp++;
            if (cz[c] !== ezc[c] || cb[c] !== eb[c] || clast[c] !== (c == 7)) begin
               n_err++; $display("FAIL rand%0d_col%0d got z=%h b=%h want z=%h b=%h", n, c, cz[c], cb[c], ezc[c], eb[c]);
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_k1();
      test_identity();
      test_gap();
      test_backpressure();
      test_relu();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
